// File: rtl/cpu_debug_ctrl.sv
// Debug controller: halts, runs, or single-steps a CPU and streams a
// dump of its debug address space over a valid/ready port.
module cpu_debug_ctrl #(
    parameter int DUMP_FIRST = 0,
    parameter int DUMP_LAST  = 127,
    parameter int DATA_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_arg,
    output logic        cmd_err,
    output logic        cpu_en,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [6:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        busy,
    output logic [31:0] cyc_cnt
);

    localparam logic [2:0] S_HALT = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_STEP = 3'd2;
    localparam logic [2:0] S_DSET = 3'd3;
    localparam logic [2:0] S_DCAP = 3'd4;
    localparam logic [2:0] S_DOUT = 3'd5;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;

    localparam logic [6:0] FIRST   = 7'(DUMP_FIRST);
    localparam logic [6:0] LAST    = 7'(DUMP_LAST);
    localparam logic [2:0] LAT_END = 3'(DATA_LAT - 1);

    logic [2:0] state;
    logic [7:0] step_left;
    logic [2:0] lat_cnt;
    logic       accept;

    assign cmd_ready  = (state == S_HALT) || (state == S_RUN);
    assign busy       = (state != S_HALT);
    assign dump_valid = (state == S_DOUT);
    assign accept     = cmd_valid && cmd_ready;

    // debug_addr doubles as the dump address pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_HALT;
            cpu_en     <= 1'b0;
            cmd_err    <= 1'b0;
            debug_addr <= 7'd0;
            dump_addr  <= 7'd0;
            dump_data  <= 32'd0;
            cyc_cnt    <= 32'd0;
            step_left  <= 8'd0;
            lat_cnt    <= 3'd0;
        end else begin
            cmd_err <= 1'b0;
            if (cpu_en)
                cyc_cnt <= cyc_cnt + 32'd1;
            case (state)
                S_HALT: begin
                    if (accept) begin
                        unique case (cmd_op)
                            OP_HALT: ;
                            OP_RUN: begin
                                state  <= S_RUN;
                                cpu_en <= 1'b1;
                            end
                            OP_STEP: begin
                                state     <= S_STEP;
                                cpu_en    <= 1'b1;
                                step_left <= (cmd_arg == 8'd0) ? 8'd1 : cmd_arg;
                            end
                            OP_DUMP: begin
                                state      <= S_DSET;
                                debug_addr <= FIRST;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (cmd_op == OP_HALT) begin
                            state  <= S_HALT;
                            cpu_en <= 1'b0;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    if (step_left <= 8'd1) begin
                        state     <= S_HALT;
                        cpu_en    <= 1'b0;
                        step_left <= 8'd0;
                    end else begin
                        step_left <= step_left - 8'd1;
                    end
                end
                S_DSET: begin
                    lat_cnt <= 3'd0;
                    state   <= S_DCAP;
                end
                S_DCAP: begin
                    if (lat_cnt == LAT_END) begin
                        dump_addr <= debug_addr;
                        dump_data <= debug_data;
                        state     <= S_DOUT;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_DOUT: begin
                    if (dump_ready) begin
                        if (debug_addr == LAST) begin
                            state <= S_HALT;
                        end else begin
                            debug_addr <= debug_addr + 7'd1;
                            state      <= S_DSET;
                        end
                    end
                end
                default: begin
                    state  <= S_HALT;
                    cpu_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl with a dump-beat scoreboard.
module tb_cpu_debug_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        cmd_err;
    logic        cpu_en;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data = 32'd0;
    logic        dump_valid;
    logic        dump_ready;
    logic [6:0]  dump_addr;
    logic [31:0] dump_data;
    logic        busy;
    logic [31:0] cyc_cnt;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } beat_t;

    beat_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    cpu_debug_ctrl dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_err(cmd_err),
        .cpu_en(cpu_en), .debug_addr(debug_addr), .debug_data(debug_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .busy(busy), .cyc_cnt(cyc_cnt)
    );

    always #5 clock = ~clock;

    // CPU debug port model: one cycle of read latency, data = addr*4
    always @(posedge clock) debug_data <= {23'd0, debug_addr, 2'b00};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".cpu_en"}, 64'(cpu_en), 64'd0);
        check({tag, ".cmd_err"}, 64'(cmd_err), 64'd0);
        check({tag, ".cyc_cnt"}, 64'(cyc_cnt), 64'd0);
        check({tag, ".debug_addr"}, 64'(debug_addr), 64'd0);
        check({tag, ".dump_valid"}, 64'(dump_valid), 64'd0);
        check({tag, ".dump_addr"}, 64'(dump_addr), 64'd0);
        check({tag, ".dump_data"}, 64'(dump_data), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic count_en(output int n, output int errs);
        n = 0;
        errs = 0;
        while (cpu_en && n < 400) begin
            n++;
            if (cmd_err) errs++;
            @(negedge clock);
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < 128; i++) q.push_back({7'(i), 32'(i * 4)});
    endtask

    initial begin
        int n;
        int errs;
        int budget;
        int en_bad;
        logic [31:0] base;
        logic hold;
        logic r;
        logic [6:0] h_addr;
        logic [31:0] h_data;
        beat_t b;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_arg = 8'd0;
        dump_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock);

        // STEP 5 with a command held during the step (must be ignored)
        send(2'd2, 8'd5);
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        check("step5.ready_low", 64'(cmd_ready), 64'd0);
        count_en(n, errs);
        cmd_valid = 1'b0;
        check("step5.count", 64'(n), 64'd5);
        check("step5.no_err", 64'(errs + int'(cmd_err)), 64'd0);
        check("step5.cyc_cnt", 64'(cyc_cnt), 64'd5);
        check("step5.busy", 64'(busy), 64'd0);
        check("step5.ready", 64'(cmd_ready), 64'd1);
        @(negedge clock);
        check("step5.stays_halt", 64'(busy), 64'd0);

        send(2'd2, 8'd0);
        count_en(n, errs);
        check("step0.count", 64'(n), 64'd1);
        check("step0.cyc_cnt", 64'(cyc_cnt), 64'd6);

        send(2'd2, 8'd255);
        count_en(n, errs);
        check("step255.count", 64'(n), 64'd255);
        check("step255.cyc_cnt", 64'(cyc_cnt), 64'd261);

        // HALT while halted: no error, no state change
        send(2'd0, 8'd0);
        check("halt_in_halt.err", 64'(cmd_err), 64'd0);
        check("halt_in_halt.busy", 64'(busy), 64'd0);

        // RUN for 20 accept-edge cycles with a rejected STEP in between
        base = cyc_cnt;
        send(2'd1, 8'd0);
        check("run.cpu_en", 64'(cpu_en), 64'd1);
        check("run.busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clock);
        send(2'd2, 8'd3);
        check("run.step_err", 64'(cmd_err), 64'd1);
        @(negedge clock);
        check("run.err_pulse", 64'(cmd_err), 64'd0);
        check("run.still_run", 64'(cpu_en), 64'd1);
        repeat (13) @(negedge clock);
        send(2'd0, 8'd0);
        check("run.cyc_cnt", 64'(cyc_cnt - base), 64'd20);
        check("run.halted", 64'(cpu_en), 64'd0);
        check("run.busy_off", 64'(busy), 64'd0);
        base = cyc_cnt;

        // DUMP, ready tied high, stray commands held throughout
        dump_ready = 1'b1;
        push_dump();
        send(2'd3, 8'd0);
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        budget = 0;
        errs = 0;
        en_bad = 0;
        while (q.size() > 0 && budget < 2000) begin
            if (cpu_en) en_bad++;
            if (cmd_err) errs++;
            if (dump_valid && dump_ready) begin
                b = q.pop_front();
                check("dump1.addr", 64'(dump_addr), 64'(b.a));
                check("dump1.data", 64'(dump_data), 64'(b.d));
            end
            budget++;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        check("dump1.left", 64'(q.size()), 64'd0);
        check("dump1.cpu_en", 64'(en_bad), 64'd0);
        check("dump1.no_err", 64'(errs), 64'd0);
        check("dump1.busy", 64'(busy), 64'd0);
        check("dump1.cyc_cnt", 64'(cyc_cnt), 64'(base));
        @(negedge clock);
        check("dump1.halt", 64'(busy), 64'd0);

        // DUMP with random backpressure
        q.delete();
        push_dump();
        dump_ready = 1'b0;
        send(2'd3, 8'd0);
        hold = 1'b0;
        h_addr = 7'd0;
        h_data = 32'd0;
        budget = 0;
        while (q.size() > 0 && budget < 4000) begin
            if (hold) begin
                check("dump2.valid_hold", 64'(dump_valid), 64'd1);
                check("dump2.addr_hold", 64'(dump_addr), 64'(h_addr));
                check("dump2.data_hold", 64'(dump_data), 64'(h_data));
            end
            r = 1'($urandom_range(0, 1));
            dump_ready = r;
            if (dump_valid && r) begin
                b = q.pop_front();
                check("dump2.addr", 64'(dump_addr), 64'(b.a));
                check("dump2.data", 64'(dump_data), 64'(b.d));
            end
            hold = dump_valid && !r;
            h_addr = dump_addr;
            h_data = dump_data;
            budget++;
            @(negedge clock);
        end
        dump_ready = 1'b0;
        check("dump2.left", 64'(q.size()), 64'd0);
        check("dump2.busy", 64'(busy), 64'd0);
        check("dump2.valid", 64'(dump_valid), 64'd0);

        // Reset in the middle of a STEP
        send(2'd2, 8'd100);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_vals("step_rst");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("step_rst.no_en", 64'(cpu_en), 64'd0);
        check("step_rst.cnt", 64'(cyc_cnt), 64'd0);

        // Reset while DOUT holds the beat for addr 40
        send(2'd3, 8'd0);
        budget = 0;
        while (!(dump_valid && dump_addr == 7'd40) && budget < 2000) begin
            dump_ready = 1'b1;
            budget++;
            @(negedge clock);
        end
        dump_ready = 1'b0;
        check("dout40.reached", 64'(dump_valid && dump_addr == 7'd40), 64'd1);
        @(negedge clock);
        check("dout40.held", 64'(dump_valid), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_vals("dout_rst");
        @(negedge clock);
        reset = 1'b0;
        dump_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("dout_rst.no_beat", 64'(dump_valid), 64'd0);
        check("dout_rst.idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_debug_ctrl.md
CPU_DEBUG_CTRL -- requirements
Module: cpu_debug_ctrl

Interface
REQ-001 The block SHALL have the parameter DUMP_FIRST, default 0, giving the first debug address scanned by a dump.
REQ-002 The block SHALL have the parameter DUMP_LAST, default 127, giving the last debug address scanned by a dump; DUMP_LAST >= DUMP_FIRST.
REQ-003 The block SHALL have the parameter DATA_LAT, default 1, giving the cycles from debug_addr change to a valid debug_data; range 1..7.
REQ-004 The block SHALL have the port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port cmd_valid, input, 1 bit: host command present.
REQ-007 The block SHALL have the port cmd_ready, output, 1 bit: the block can accept a command this cycle.
REQ-008 The block SHALL have the port cmd_op, input, 2 bits: 0=HALT, 1=RUN, 2=STEP, 3=DUMP.
REQ-009 The block SHALL have the port cmd_arg, input, 8 bits: step count for STEP, otherwise ignored.
REQ-010 The block SHALL have the port cmd_err, output, 1 bit: one-cycle pulse when an accepted command is ignored.
REQ-011 The block SHALL have the port cpu_en, output, 1 bit: per-cycle CPU advance enable (drives the CPU step input).
REQ-012 The block SHALL have the port debug_addr, output, 7 bits: CPU debug read address.
REQ-013 The block SHALL have the port debug_data, input, 32 bits: CPU debug read data.
REQ-014 The block SHALL have the ports dump_valid (output, 1 bit), dump_ready (input, 1 bit), dump_addr (output, 7 bits) and dump_data (output, 32 bits), forming the dump output stream.
REQ-015 The block SHALL have the ports busy (output, 1 bit: state not HALT) and cyc_cnt (output, 32 bits: count of cycles with cpu_en=1).

Function
REQ-016 The FSM SHALL have the states HALT, RUN, STEP, DSET, DCAP and DOUT; cmd_ready SHALL be 1 only in HALT and RUN.
REQ-017 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1, and SHALL take effect in the next cycle.
REQ-018 In HALT: RUN goes to RUN; STEP goes to STEP with step_left=cmd_arg (0 treated as 1); DUMP goes to DSET with addr=DUMP_FIRST; HALT stays in HALT with no error.
REQ-019 In RUN: HALT goes to HALT; RUN, STEP or DUMP SHALL be accepted, ignored, and pulse cmd_err the following cycle.
REQ-020 cpu_en SHALL be registered and equal 1 exactly in the cycles spent in RUN or STEP.
REQ-021 STEP SHALL assert cpu_en for exactly step_left consecutive cycles (1..255), then enter HALT; it SHALL not be interruptible.
REQ-022 DSET SHALL drive debug_addr=addr, then DCAP SHALL wait DATA_LAT cycles and capture debug_data into dump_data, with dump_addr=addr.
REQ-023 DOUT SHALL hold dump_valid=1 with dump_addr and dump_data stable until dump_ready=1; on handshake it SHALL go to DSET with addr+1, or to HALT if addr==DUMP_LAST.
REQ-024 cpu_en SHALL be 0 throughout DSET, DCAP and DOUT.
REQ-025 cyc_cnt SHALL increment on each cycle with cpu_en=1 and wrap from 0xFFFFFFFF to 0.
REQ-026 cmd_valid SHALL be ignored in STEP and in the dump states, and no cmd_err SHALL be raised for it.
REQ-027 debug_addr SHALL hold its last value outside the dump states.

Reset
REQ-028 Reset SHALL act asynchronously, setting: state HALT, cpu_en 0, cmd_ready 1, cmd_err 0, debug_addr 0, dump_valid 0, dump_addr 0, dump_data 0, busy 0, cyc_cnt 0, step_left 0.
REQ-029 Reset asserted mid-STEP or mid-dump SHALL abort the operation immediately, with no further dump beat and no further cpu_en cycle.

Verification
REQ-030 Test STEP with cmd_arg=5 from HALT: cpu_en high for exactly 5 cycles, cyc_cnt=5, then busy=0 and cmd_ready=1.
REQ-031 Test STEP with cmd_arg=0: exactly 1 cpu_en cycle.
REQ-032 Test RUN for 20 cycles, then HALT: cyc_cnt=20±0 relative to the accept edges; a STEP sent during RUN gives a cmd_err pulse with no state change.
REQ-033 Test DUMP with dump_ready tied to 1, debug_data=addr*4: 128 beats, with dump_addr 0..127 in order and dump_data equal to 4*dump_addr.
REQ-034 Test DUMP with random dump_ready backpressure: no beat lost or duplicated, and dump_data stable while valid and not ready.
REQ-035 Test reset asserted during DOUT at addr 40: dump_valid drops asynchronously, and all outputs equal their reset values.
